// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and defaults for the two-client register-file arbiter
package regfile_arb_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        A = 1'b0,
        B = 1'b1
    } client_e;

    function automatic client_e other_client(input client_e c);
        return (c == A) ? B : A;
    endfunction

endpackage

// File: rtl/regfile_arb_rr_sel2.sv
// rtl/regfile_arb_rr_sel2.sv - two-way round-robin pick between clients A and B
module rr_sel2
    import regfile_arb_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  client_e ptr,
    output client_e gnt,
    output logic    valid
);

    // A lone requester always wins; on contention the pointer names the winner.
    always_comb begin
        gnt   = A;
        valid = req_a | req_b;
        if (req_a && req_b) begin
            gnt = ptr;
        end else if (req_b) begin
            gnt = B;
        end
    end

endmodule

// File: rtl/regfile_arb.sv
// rtl/regfile_arb.sv - IDLE/ACCESS/DONE arbiter sharing one register-file port between two clients; REGFILE_ARB_STATS_EN adds per-client ack counters
module regfile_arb
    import regfile_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_num,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_num,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          rf_write,
    output logic [AW-1:0] rf_writenum,
    output logic [AW-1:0] rf_readnum,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [7:0]    a_cnt,
    output logic [7:0]    b_cnt
`endif
);

    state_e        state_q, state_d;
    client_e       ptr_q, ptr_d;
    client_e       win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] num_q, num_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic [DW-1:0] capture;

    client_e       sel_gnt;
    logic          sel_valid;

    rr_sel2 u_sel (
        .req_a (a_req),
        .req_b (b_req),
        .ptr   (ptr_q),
        .gnt   (sel_gnt),
        .valid (sel_valid)
    );

    // State and latched request fields; async reset kills an in-flight write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= A;
            win_q     <= A;
            we_q      <= 1'b0;
            num_q     <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            we_q      <= we_d;
            num_q     <= num_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Next state: grant and latch in IDLE, perform the access, then one ack cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        we_d      = we_q;
        num_d     = num_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        capture   = we_q ? wdata_q : rf_data_out;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = ACCESS;
                    win_d   = sel_gnt;
                    if (sel_gnt == A) begin
                        we_d    = a_we;
                        num_d   = a_num;
                        wdata_d = a_wdata;
                    end else begin
                        we_d    = b_we;
                        num_d   = b_num;
                        wdata_d = b_wdata;
                    end
                    // Only contention moves the pointer, and it moves to the loser.
                    if (a_req && b_req) begin
                        ptr_d = other_client(sel_gnt);
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (win_q == A) begin
                    a_rdata_d = capture;
                end else begin
                    b_rdata_d = capture;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rf_write    = (state_q == ACCESS) && we_q;
    assign rf_writenum = num_q;
    assign rf_readnum  = num_q;
    assign rf_data_in  = wdata_q;
    assign a_ack       = (state_q == DONE) && (win_q == A);
    assign b_ack       = (state_q == DONE) && (win_q == B);
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;

`ifdef REGFILE_ARB_STATS_EN
    logic [7:0] a_cnt_q, b_cnt_q;

    // Saturating per-client completion counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_cnt_q <= 8'd0;
            b_cnt_q <= 8'd0;
        end else begin
            if (a_ack && (a_cnt_q != 8'hFF)) begin
                a_cnt_q <= a_cnt_q + 8'd1;
            end
            if (b_ack && (b_cnt_q != 8'hFF)) begin
                b_cnt_q <= b_cnt_q + 8'd1;
            end
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_arb.sv
// tb/tb_regfile_arb.sv - directed self-checking bench for regfile_arb
module tb_regfile_arb;

    logic        clk;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_num, b_num;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic        rf_write;
    logic [2:0]  rf_writenum, rf_readnum;
    logic [15:0] rf_data_in, rf_data_out;
`ifdef REGFILE_ARB_STATS_EN
    logic [7:0]  a_cnt, b_cnt;
`endif

    logic [15:0] rf_mem [8];

    int n_vec = 0;
    int n_bad = 0;

    regfile_arb #(.DW(16), .AW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_num       (a_num),
        .a_wdata     (a_wdata),
        .a_ack       (a_ack),
        .a_rdata     (a_rdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_num       (b_num),
        .b_wdata     (b_wdata),
        .b_ack       (b_ack),
        .b_rdata     (b_rdata),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_readnum  (rf_readnum),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .a_cnt       (a_cnt),
        .b_cnt       (b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file outside the arbiter: combinational read, clocked write.
    always @(posedge clk) begin
        if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    end
    assign rf_data_out = rf_mem[rf_readnum];

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        a_req = 0; a_we = 0; a_num = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_num = 0; b_wdata = 0;
    endtask

    task automatic reset_dut();
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    // One access by a single client; ack must land on the second edge after req is seen.
    task automatic do_access(input string tag, input bit cl, input bit we,
                             input logic [2:0] num, input logic [15:0] wd);
        int cyc;
        bit got;
        if (!cl) begin
            a_req = 1; a_we = we; a_num = num; a_wdata = wd;
        end else begin
            b_req = 1; b_we = we; b_num = num; b_wdata = wd;
        end
        cyc = 0;
        got = 0;
        while (!got && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
            got = cl ? b_ack : a_ack;
        end
        check_vec({tag, "_lat"}, cyc, 2);
        check_vec({tag, "_other_ack"}, cl ? a_ack : b_ack, 0);
        if (!cl) a_req = 0; else b_req = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acks;
        reset = 1;
        clear_inputs();
        #1;
        check_vec("rst_a_ack", a_ack, 0);
        check_vec("rst_b_ack", b_ack, 0);
        check_vec("rst_a_rdata", a_rdata, 0);
        check_vec("rst_b_rdata", b_rdata, 0);
        check_vec("rst_rf_write", rf_write, 0);
        check_vec("rst_rf_num", rf_writenum, 0);
        check_vec("rst_rf_din", rf_data_in, 0);
        reset_dut();

        // Single client write then read of R0.
        do_access("a_wr_r0", 0, 1, 3'd0, 16'h002A);
        check_vec("a_wr_r0_mem", rf_mem[0], 16'h002A);
        check_vec("a_wr_r0_rdata", a_rdata, 16'h002A);
        do_access("a_rd_r0", 0, 0, 3'd0, 16'h0000);
        check_vec("a_rd_r0_rdata", a_rdata, 16'h002A);

        // Simultaneous requests right after reset: A (write R1) first, then B (read R1).
        reset_dut();
        a_req = 1; a_we = 1; a_num = 3'd1; a_wdata = 16'h0027;
        b_req = 1; b_we = 0; b_num = 3'd1; b_wdata = 16'h0000;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("sim_a_ack_%0d", i), a_ack, (i == 2));
            check_vec($sformatf("sim_b_ack_%0d", i), b_ack, (i == 5));
            check_vec($sformatf("sim_wr_%0d", i), rf_write, (i == 1));
            if (i == 2) a_req = 0;
            if (i == 5) b_req = 0;
        end
        check_vec("sim_mem_r1", rf_mem[1], 16'h0027);
        check_vec("sim_b_rdata", b_rdata, 16'h0027);
        check_vec("sim_a_rdata", a_rdata, 16'h0027);

        // Isolation: B reads R7 while A stays idle.
        do_access("b_wr_r7", 1, 1, 3'd7, 16'h1234);
        do_access("b_wr_r6", 1, 1, 3'd6, 16'h0006);
        check_vec("b_wr_r6_rdata", b_rdata, 16'h0006);
        b_req = 1; b_we = 0; b_num = 3'd7;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("iso_b_ack_%0d", i), b_ack, (i == 2));
            check_vec($sformatf("iso_a_ack_%0d", i), a_ack, 0);
            check_vec($sformatf("iso_wr_%0d", i), rf_write, 0);
            if (i == 2) b_req = 0;
        end
        check_vec("iso_b_rdata", b_rdata, 16'h1234);
        check_vec("iso_a_rdata", a_rdata, 16'h0027);

        // Reset asserted during the ACCESS cycle of a write to R5.
        do_access("a_wr_r5", 0, 1, 3'd5, 16'h5555);
        check_vec("pre_r5_mem", rf_mem[5], 16'h5555);
        a_req = 1; a_we = 1; a_num = 3'd5; a_wdata = 16'h00FF;
        @(posedge clk);
        #1;
        check_vec("mid_access_wr", rf_write, 1);
        check_vec("mid_access_din", rf_data_in, 16'h00FF);
        #1;
        reset = 1;
        #1;
        check_vec("mid_rst_wr", rf_write, 0);
        check_vec("mid_rst_a_ack", a_ack, 0);
        check_vec("mid_rst_b_ack", b_ack, 0);
        check_vec("mid_rst_a_rdata", a_rdata, 0);
        check_vec("mid_rst_b_rdata", b_rdata, 0);
        check_vec("mid_rst_num", rf_writenum, 0);
        check_vec("mid_rst_din", rf_data_in, 0);
        a_req = 0;
        @(posedge clk);
        #1;
        check_vec("mid_rst_r5_kept", rf_mem[5], 16'h5555);
        reset = 0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("post_rst_a_ack_%0d", i), a_ack, 0);
            check_vec($sformatf("post_rst_wr_%0d", i), rf_write, 0);
        end
        check_vec("post_rst_r5", rf_mem[5], 16'h5555);

        // Continuous contention for 12 cycles: A, B, A, B with writes only in ACCESS.
        reset_dut();
        a_req = 1; a_we = 1; a_num = 3'd2; a_wdata = 16'hAAAA;
        b_req = 1; b_we = 1; b_num = 3'd3; b_wdata = 16'hBBBB;
        acks = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("cont_wr_%0d", i), rf_write, (i % 3 == 1));
            check_vec($sformatf("cont_a_ack_%0d", i), a_ack, (i % 3 == 2) && ((i / 3) % 2 == 0));
            check_vec($sformatf("cont_b_ack_%0d", i), b_ack, (i % 3 == 2) && ((i / 3) % 2 == 1));
            acks += int'(a_ack) + int'(b_ack);
        end
        clear_inputs();
        check_vec("cont_ack_count", acks, 4);
        check_vec("cont_mem_r2", rf_mem[2], 16'hAAAA);
        check_vec("cont_mem_r3", rf_mem[3], 16'hBBBB);
        @(posedge clk);
        #1;

`ifdef REGFILE_ARB_STATS_EN
        // Saturating ack counters.
        reset_dut();
        check_vec("cnt_rst_a", a_cnt, 0);
        check_vec("cnt_rst_b", b_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            do_access("cnt_a", 0, 0, 3'd0, 16'h0000);
            if (i == 9) check_vec("cnt_a_10", a_cnt, 10);
        end
        check_vec("cnt_a_sat", a_cnt, 255);
        check_vec("cnt_b_zero", b_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameter: DW, 16, data width of the register file and both client data paths.
REQ-002 Parameter: AW, 3, register index width (2**AW registers).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports, client A: a_req in 1 (request); a_we in 1 (1 = write, 0 = read); a_num in AW (register index); a_wdata in DW (write data); a_ack out 1 (done pulse); a_rdata out DW (read data).
REQ-006 Ports, client B: b_req, b_we, b_num, b_wdata, b_ack, b_rdata, with the same directions, widths and meanings as client A.
REQ-007 Ports, to the register file: rf_write out 1; rf_writenum out AW; rf_readnum out AW; rf_data_in out DW; rf_data_out in DW, with combinational read of rf_readnum and a write on the rising edge when rf_write is 1.

Function
REQ-008 The arbiter SHALL share the single register-file port pair between clients A and B using a three-state FSM: IDLE, ACCESS, DONE.
REQ-009 IDLE: if any req is 1, the arbiter SHALL select a winner, latch that winner's we/num/wdata and id, and go to ACCESS; otherwise it stays in IDLE.
REQ-010 Selection: a single requester wins; if both request, the round-robin pointer decides; the pointer SHALL then point at the loser.
REQ-011 ACCESS lasts one cycle: rf_writenum = rf_readnum = latched num and rf_data_in = latched wdata; rf_write = latched we.
REQ-012 In ACCESS on a read, rf_data_out SHALL be captured into the winner's rdata register; on a write, the winner's rdata SHALL be loaded with the written data.
REQ-013 DONE: the winner's ack SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; the loser's ack stays 0.
REQ-014 Latency: with req first seen at edge k, the register write commits at edge k+1 and ack is high in the cycle after edge k+1; throughput is one access per 3 cycles.
REQ-015 Clients SHALL hold req/we/num/wdata stable until ack and SHALL drop req in the cycle after ack; a req still high in IDLE counts as a new request.
REQ-016 rf_write SHALL be 0 in IDLE and DONE; outputs SHALL be decoded from registered state only (no combinational path from req to rf_write).
REQ-017 a_rdata/b_rdata SHALL hold their value until the same client's next completed access.
REQ-018 Back-to-back contention: with both req held continuously, grants SHALL alternate A, B, A, B.

Reset
REQ-019 While reset = 1: state = IDLE, pointer = A, a_ack = b_ack = 0, a_rdata = b_rdata = 0, rf_write = 0, and latched fields = 0.
REQ-020 Reset asserted during ACCESS SHALL force rf_write to 0 immediately (asynchronously), so no write commits; the access is dropped with no ack.

Configuration
REQ-021 Macro REGFILE_ARB_STATS_EN: when defined, the block SHALL add outputs a_cnt and b_cnt (8 bits each). Each SHALL increment on that client's ack and saturate at 255; both reset to 0.
REQ-022 When REGFILE_ARB_STATS_EN is not defined, the ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Package regfile_arb_pkg SHALL hold the state typedef (IDLE/ACCESS/DONE), the client-id typedef (A/B) and the default DW/AW constants.
REQ-024 Sub-module rr_sel2 SHALL hold the 2-way round-robin pick logic (inputs: two reqs and the pointer; outputs: grant id and valid). The register file stays outside this block.

Verification
REQ-025 Reset mid-run: assert reset in ACCESS for a write of 0x00FF to R5 -> R5 unchanged, no ack, and all outputs at their reset values.
REQ-026 Single write then read: A writes 0x002A to R0, then reads R0 -> a_ack pulses twice, each 2 cycles after req is seen, and a_rdata = 0x002A.
REQ-027 Simultaneous requests after reset: A writes 0x0027 to R1 and B reads R1 in the same cycle -> A is served first, then B, and b_rdata = 0x0027.
REQ-028 Continuous contention: both req held for 12 cycles -> exactly 4 acks alternating A, B, A, B, and rf_write is never 1 outside ACCESS.
REQ-029 Isolation: B reads R7 while A is idle -> only b_ack pulses, a_rdata is unchanged, and rf_write stays 0.
REQ-030 With REGFILE_ARB_STATS_EN defined: 300 A accesses -> a_cnt = 255 (saturated) and b_cnt = 0.
